// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-index width, zero-register constant and the
// hazard controller state encoding.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  localparam regbits_t REG_ZERO = 5'd0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read
// by the instruction in ID. Writes to the zero register never create a hazard.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  input  logic       idex_dREN,
  input  logic [4:0] idex_wsel,
  output logic       load_use
);

  regbits_t wsel;
  logic     rsMatch;
  logic     rtMatch;

  assign wsel = idex_wsel;

  // Compare the EX destination against each source the ID instruction reads
  always_comb begin
    rsMatch  = (wsel == regbits_t'(ifid_rs));
    rtMatch  = ifid_uses_rt & (wsel == regbits_t'(ifid_rt));
    load_use = idex_dREN & (wsel != REG_ZERO) & (rsMatch | rtMatch);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline. Drives every
// pipeline-register enable/flush, the EX/MEM clearMemReq and the PC enable.
// Optional feature macro: PIPE_HAZARD_PERF_EN enables saturating stall and
// flush performance counters; without it both counter ports read zero.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_dREN,
  input  logic [4:0]       idex_wsel,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             exmem_clearMemReq,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state_q;
  hazard_state_t state_d;

  logic loadUse;
  logic memReq;
  logic memBusy;
  logic advance;

  hazard_detect u_hazard_detect (
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .idex_dREN    (idex_dREN),
    .idex_wsel    (idex_wsel),
    .load_use     (loadUse)
  );

  assign memReq  = exmem_dREN | exmem_dWEN;
  assign memBusy = memReq & ~dhit;
  assign advance = (state_q == RUN) & ihit & ~memBusy;

  // State register: reset always returns to RUN, HALT is otherwise sticky
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a halt reaching WB freezes the pipeline from the next cycle on
  always_comb begin
    state_d = state_q;
    if ((state_q == RUN) && memwb_halt) begin
      state_d = HALT;
    end
  end

  // Control outputs: reset flushes everything, HALT freezes, otherwise the
  // redirect/bubble priority applies only when the pipeline can advance
  always_comb begin
    pc_en             = 1'b0;
    ifid_en           = 1'b0;
    ifid_flush        = 1'b0;
    idex_en           = 1'b0;
    idex_flush        = 1'b0;
    exmem_en          = 1'b0;
    exmem_flush       = 1'b0;
    exmem_clearMemReq = 1'b0;
    memwb_en          = 1'b0;
    memwb_flush       = 1'b0;
    halted            = 1'b0;
    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == HALT) begin
      halted = 1'b1;
    end else begin
      exmem_clearMemReq = dhit & memReq;
      if (advance) begin
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        idex_en  = 1'b1;
        if (ex_branch_taken) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (loadUse) begin
          idex_flush = 1'b1;
        end else if (id_jump) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             stallEvent;
  logic             flushEvent;

  // Classify this cycle as a stall (freeze or bubble) and/or a flush cycle
  always_comb begin
    stallEvent = (state_q == RUN) & (~advance | (~ex_branch_taken & loadUse));
    flushEvent = ifid_flush | idex_flush | exmem_flush | memwb_flush;
  end

  // Saturating counters, cleared by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stallEvent && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flushEvent && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit;
  logic             dhit;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             idex_dREN;
  logic [4:0]       idex_wsel;
  logic             exmem_dREN;
  logic             exmem_dWEN;
  logic             ex_branch_taken;
  logic             id_jump;
  logic             memwb_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             exmem_clearMemReq;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int passCount = 0;
  int totalCount = 0;

  // Order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush
  //        clearMemReq memwb_en memwb_flush halted
  logic [10:0] ctrlVec;
  assign ctrlVec = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                    exmem_flush, exmem_clearMemReq, memwb_en, memwb_flush, halted};

  localparam logic [10:0] V_RESET  = 11'b0_0_1_0_1_0_1_0_0_1_0;
  localparam logic [10:0] V_RUN    = 11'b1_1_0_1_0_1_0_0_1_0_0;
  localparam logic [10:0] V_FROZEN = 11'b0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] V_CLRADV = 11'b1_1_0_1_0_1_0_1_1_0_0;
  localparam logic [10:0] V_CLRFRZ = 11'b0_0_0_0_0_0_0_1_0_0_0;
  localparam logic [10:0] V_BRANCH = 11'b1_1_1_1_1_1_0_0_1_0_0;
  localparam logic [10:0] V_JUMP   = 11'b1_1_1_1_0_1_0_0_1_0_0;
  localparam logic [10:0] V_HALTED = 11'b0_0_0_0_0_0_0_0_0_0_1;

`ifdef PIPE_HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] EXP_MEM_STALLS = 3;
`else
  localparam logic [CNT_W-1:0] EXP_MEM_STALLS = 0;
`endif

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .ihit              (ihit),
    .dhit              (dhit),
    .ifid_rs           (ifid_rs),
    .ifid_rt           (ifid_rt),
    .ifid_uses_rt      (ifid_uses_rt),
    .idex_dREN         (idex_dREN),
    .idex_wsel         (idex_wsel),
    .exmem_dREN        (exmem_dREN),
    .exmem_dWEN        (exmem_dWEN),
    .ex_branch_taken   (ex_branch_taken),
    .id_jump           (id_jump),
    .memwb_halt        (memwb_halt),
    .pc_en             (pc_en),
    .ifid_en           (ifid_en),
    .ifid_flush        (ifid_flush),
    .idex_en           (idex_en),
    .idex_flush        (idex_flush),
    .exmem_en          (exmem_en),
    .exmem_flush       (exmem_flush),
    .exmem_clearMemReq (exmem_clearMemReq),
    .memwb_en          (memwb_en),
    .memwb_flush       (memwb_flush),
    .halted            (halted),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Return all data-path inputs to a quiet, hazard-free pattern
  task automatic set_idle();
    ihit            = 1'b0;
    dhit            = 1'b0;
    ifid_rs         = 5'd1;
    ifid_rt         = 5'd2;
    ifid_uses_rt    = 1'b1;
    idex_dREN       = 1'b0;
    idex_wsel       = 5'd3;
    exmem_dREN      = 1'b0;
    exmem_dWEN      = 1'b0;
    ex_branch_taken = 1'b0;
    id_jump         = 1'b0;
    memwb_halt      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    set_idle();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    set_idle();
    RST = 1'b1;
    ihit = 1'b1;
    #1;
    totalCount++;
    if (ctrlVec !== V_RESET) $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrlVec, V_RESET);
    else passCount++;
    @(negedge CLK);
    totalCount++;
    if (stall_cnt !== '0 || flush_cnt !== '0)
      $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    else passCount++;
    RST = 1'b0;
    #1;
    totalCount++;
    if (ctrlVec !== V_RUN) $display("[TB] FAIL run_after_reset: got %b expected %b", ctrlVec, V_RUN);
    else passCount++;
    ihit = 1'b0;
    #1;
    totalCount++;
    if (ctrlVec !== V_FROZEN) $display("[TB] FAIL ifetch_wait: got %b expected %b", ctrlVec, V_FROZEN);
    else passCount++;
  endtask

  task automatic test_load_use();
    @(negedge CLK);
    set_idle();
    ihit = 1'b1;
    idex_dREN = 1'b1;
    idex_wsel = 5'd5;
    ifid_rs = 5'd5;
    #1;
    totalCount++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en} !== 6'b0_0_0_1_1_1)
      $display("[TB] FAIL load_use_rs: got %b expected 000111",
               {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en});
    else passCount++;
    // bubble inserted: the load has moved on, hazard gone
    @(negedge CLK);
    idex_dREN = 1'b0;
    #1;
    totalCount++;
    if (ctrlVec !== V_RUN) $display("[TB] FAIL after_bubble: got %b expected %b", ctrlVec, V_RUN);
    else passCount++;
    // rt match only counts when the instruction reads rt
    @(negedge CLK);
    idex_dREN = 1'b1;
    idex_wsel = 5'd9;
    ifid_rs = 5'd1;
    ifid_rt = 5'd9;
    ifid_uses_rt = 1'b1;
    #1;
    totalCount++;
    if ({pc_en, ifid_en, idex_flush} !== 3'b001)
      $display("[TB] FAIL load_use_rt: got %b expected 001", {pc_en, ifid_en, idex_flush});
    else passCount++;
    ifid_uses_rt = 1'b0;
    #1;
    totalCount++;
    if (ctrlVec !== V_RUN) $display("[TB] FAIL itype_no_rt: got %b expected %b", ctrlVec, V_RUN);
    else passCount++;
    // load to the zero register is never a hazard
    @(negedge CLK);
    idex_wsel = 5'd0;
    ifid_rs = 5'd0;
    ifid_uses_rt = 1'b1;
    #1;
    totalCount++;
    if (ctrlVec !== V_RUN) $display("[TB] FAIL zero_reg: got %b expected %b", ctrlVec, V_RUN);
    else passCount++;
  endtask

  task automatic test_mem_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_idle();
      ihit = 1'b1;
      exmem_dREN = 1'b1;
      #1;
      totalCount++;
      if (ctrlVec !== V_FROZEN) $display("[TB] FAIL mem_wait%0d: got %b expected %b", i, ctrlVec, V_FROZEN);
      else passCount++;
      @(negedge CLK);
    end
    dhit = 1'b1;
    #1;
    totalCount++;
    if (ctrlVec !== V_CLRADV) $display("[TB] FAIL dhit_ihit: got %b expected %b", ctrlVec, V_CLRADV);
    else passCount++;
    @(negedge CLK);
    set_idle();
    totalCount++;
    if (stall_cnt !== EXP_MEM_STALLS || flush_cnt !== '0)
      $display("[TB] FAIL mem_counters: got %0d/%0d expected %0d/0", stall_cnt, flush_cnt, EXP_MEM_STALLS);
    else passCount++;
    // data returns before the fetch does
    exmem_dWEN = 1'b1;
    dhit = 1'b1;
    #1;
    totalCount++;
    if (ctrlVec !== V_CLRFRZ) $display("[TB] FAIL dhit_first: got %b expected %b", ctrlVec, V_CLRFRZ);
    else passCount++;
    @(negedge CLK);
    set_idle();
    ihit = 1'b1;
    #1;
    totalCount++;
    if (ctrlVec !== V_RUN) $display("[TB] FAIL ihit_after_dhit: got %b expected %b", ctrlVec, V_RUN);
    else passCount++;
  endtask

  task automatic test_redirect();
    @(negedge CLK);
    set_idle();
    ihit = 1'b1;
    ex_branch_taken = 1'b1;
    id_jump = 1'b1;
    idex_dREN = 1'b1;
    idex_wsel = 5'd7;
    ifid_rs = 5'd7;
    #1;
    totalCount++;
    if (ctrlVec !== V_BRANCH) $display("[TB] FAIL branch_priority: got %b expected %b", ctrlVec, V_BRANCH);
    else passCount++;
    ex_branch_taken = 1'b0;
    #1;
    totalCount++;
    if ({pc_en, ifid_flush, idex_flush} !== 3'b001)
      $display("[TB] FAIL loaduse_over_jump: got %b expected 001", {pc_en, ifid_flush, idex_flush});
    else passCount++;
    idex_dREN = 1'b0;
    #1;
    totalCount++;
    if (ctrlVec !== V_JUMP) $display("[TB] FAIL jump: got %b expected %b", ctrlVec, V_JUMP);
    else passCount++;
    ihit = 1'b0;
    #1;
    totalCount++;
    if (ctrlVec !== V_FROZEN) $display("[TB] FAIL flush_needs_advance: got %b expected %b", ctrlVec, V_FROZEN);
    else passCount++;
  endtask

  task automatic test_halt();
    @(negedge CLK);
    set_idle();
    ihit = 1'b1;
    memwb_halt = 1'b1;
    #1;
    totalCount++;
    if (ctrlVec !== V_RUN) $display("[TB] FAIL halt_entry_cycle: got %b expected %b", ctrlVec, V_RUN);
    else passCount++;
    @(negedge CLK);
    memwb_halt = 1'b0;
    #1;
    totalCount++;
    if (ctrlVec !== V_HALTED) $display("[TB] FAIL halted_ihit: got %b expected %b", ctrlVec, V_HALTED);
    else passCount++;
    @(negedge CLK);
    dhit = 1'b1;
    exmem_dREN = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    totalCount++;
    if (ctrlVec !== V_HALTED) $display("[TB] FAIL halted_sticky: got %b expected %b", ctrlVec, V_HALTED);
    else passCount++;
    RST = 1'b1;
    #1;
    totalCount++;
    if (ctrlVec !== V_RESET) $display("[TB] FAIL reset_in_halt: got %b expected %b", ctrlVec, V_RESET);
    else passCount++;
    @(negedge CLK);
    RST = 1'b0;
    set_idle();
    ihit = 1'b1;
    #1;
    totalCount++;
    if (ctrlVec !== V_RUN) $display("[TB] FAIL run_after_halt_reset: got %b expected %b", ctrlVec, V_RUN);
    else passCount++;
  endtask

  task automatic test_reset_mid_stall();
    @(negedge CLK);
    set_idle();
    ihit = 1'b1;
    exmem_dREN = 1'b1;
    RST = 1'b1;
    #1;
    totalCount++;
    if (ctrlVec !== V_RESET) $display("[TB] FAIL reset_mid_stall: got %b expected %b", ctrlVec, V_RESET);
    else passCount++;
    @(negedge CLK);
    RST = 1'b0;
    exmem_dREN = 1'b0;
    #1;
    totalCount++;
    if (ctrlVec !== V_RUN) $display("[TB] FAIL run_after_stall_reset: got %b expected %b", ctrlVec, V_RUN);
    else passCount++;
  endtask

  initial begin
    RST = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_mem_stall();
    test_redirect();
    test_halt();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
